gauss3x3_blur_ctrl: RTL and testbench

//   Sequences 3x3 Gaussian blur over an image held in the word-addressed pixel memory (one pixel per word).

---
 rtl/gauss3x3_blur_ctrl.sv | 130 +++++++++++++
 tb/tb_gauss3x3_blur_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/gauss3x3_blur_ctrl.sv
// 3x3 Gaussian blur sequencer: walks each interior window, issues 9 reads,
// accumulates 1-2-1 weighted samples and emits one rounded pixel per window.
module gauss3x3_blur_ctrl #(
    parameter int IMG_W  = 5,
    parameter int IMG_H  = 5,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PIX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_out,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              done
);
    localparam int NWIN  = (IMG_W - 2) * (IMG_H - 2);
    localparam int ACC_W = PIX_W + 4;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_EMIT, S_DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] ox, oy, widx;
    logic [1:0]        r, c, r_d, c_d;
    logic              rd_vld;
    logic [ACC_W-1:0]  acc, acc_nxt, term, rsum;
    logic [1:0]        sh;
    logic              fetch_end, last_win;

    assign fetch_end = (r == 2'd2) && (c == 2'd2);
    assign last_win  = (widx == ADDR_W'(NWIN - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (fetch_end) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_EMIT;
            S_EMIT:  state_nxt = last_win ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Weight is a power of two: shift by one for the middle row and middle column.
    always_comb begin
        sh      = {1'b0, r_d == 2'd1} + {1'b0, c_d == 2'd1};
        term    = ACC_W'(mem_dout[PIX_W-1:0]) << sh;
        acc_nxt = rd_vld ? acc + term : acc;
        rsum    = acc_nxt + ACC_W'(8);
    end

    always_comb begin
        mem_addr = '0;
        if (state == S_FETCH)
            mem_addr = ADDR_W'((int'(oy) + int'(r)) * IMG_W + int'(ox) + int'(c));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ox        <= '0;
            oy        <= '0;
            widx      <= '0;
            r         <= '0;
            c         <= '0;
            r_d       <= '0;
            c_d       <= '0;
            rd_vld    <= 1'b0;
            acc       <= '0;
            busy      <= 1'b0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
            pix_idx   <= '0;
            done      <= 1'b0;
        end else begin
            state  <= state_nxt;
            rd_vld <= (state == S_FETCH);
            r_d    <= r;
            c_d    <= c;
            busy   <= (state_nxt != S_IDLE);

            if (state == S_FETCH) begin
                if (c == 2'd2) begin
                    c <= '0;
                    r <= (r == 2'd2) ? 2'd0 : r + 2'd1;
                end else begin
                    c <= c + 2'd1;
                end
            end else begin
                r <= '0;
                c <= '0;
            end

            if (state != S_FETCH && state_nxt == S_FETCH)
                acc <= '0;
            else
                acc <= acc_nxt;

            // The 9th sample lands during DRAIN, so the result is taken from acc_nxt.
            pix_valid <= (state == S_DRAIN);
            if (state == S_DRAIN) begin
                pix_out <= rsum[ACC_W-1:4];
                pix_idx <= widx;
            end

            if (state == S_EMIT) begin
                if (last_win) begin
                    ox   <= '0;
                    oy   <= '0;
                    widx <= '0;
                end else begin
                    widx <= widx + 1'b1;
                    if (ox == ADDR_W'(IMG_W - 3)) begin
                        ox <= '0;
                        oy <= oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
            end

            done <= (state == S_EMIT) && last_win;
        end
    end
endmodule

// File: tb/tb_gauss3x3_blur_ctrl.sv
// Randomized self-checking bench for gauss3x3_blur_ctrl on a 5x5 image with a
// synchronous-read memory model and an arithmetic blur reference.
module tb_gauss3x3_blur_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  mem_addr;
    logic [31:0] mem_dout;
    logic        busy, pix_valid, done;
    logic [7:0]  pix_out;
    logic [4:0]  pix_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] img [0:24];
    int          refp [0:8];

    gauss3x3_blur_ctrl #(.IMG_W(5), .IMG_H(5), .ADDR_W(5), .DATA_W(32), .PIX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .busy(busy), .pix_valid(pix_valid), .pix_out(pix_out), .pix_idx(pix_idx), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dout <= (mem_addr < 5'd25) ? img[mem_addr] : $urandom;

    task automatic compute_ref();
        for (int i = 0; i < 9; i++) begin
            int sum;
            sum = 0;
            for (int dy = 0; dy < 3; dy++)
                for (int dx = 0; dx < 3; dx++) begin
                    int w, p;
                    w = (dy == 1 ? 2 : 1) * (dx == 1 ? 2 : 1);
                    p = int'(img[(i / 3 + dy) * 5 + (i % 3) + dx] & 32'hFF);
                    sum += w * p;
                end
            refp[i] = (sum + 8) / 16;
        end
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < 25; i++) img[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 25; i++) img[i] = $urandom;
    endtask

    // mode 0: single start pulse; mode 1: extra start pulses at cycles 30 and 100.
    task automatic do_run(input string nm, input int mode);
        int nstrobe, ndone;
        nstrobe = 0;
        ndone = 0;
        compute_ref();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 101; cyc++) begin
            int p, w, ea, ei;
            logic ev;
            if (mode == 1) start = (cyc == 30 || cyc == 100);
            p  = (cyc - 1) % 11;
            w  = (cyc - 1) / 11;
            ea = (w < 9 && p < 9) ? ((w / 3 + p / 3) * 5 + (w % 3) + (p % 3)) : 0;
            ev = (cyc % 11 == 0) && (cyc <= 99);
            checks += 4;
            if (mem_addr !== 5'(ea)) begin
                errors++;
                $display("FAIL %s addr cyc %0d: got %0d want %0d", nm, cyc, mem_addr, ea);
            end
            if (busy !== (cyc <= 100)) begin
                errors++;
                $display("FAIL %s busy cyc %0d: got %b want %b", nm, cyc, busy, cyc <= 100);
            end
            if (pix_valid !== ev) begin
                errors++;
                $display("FAIL %s pix_valid cyc %0d: got %b want %b", nm, cyc, pix_valid, ev);
            end
            if (done !== (cyc == 100)) begin
                errors++;
                $display("FAIL %s done cyc %0d: got %b want %b", nm, cyc, done, cyc == 100);
            end
            if (pix_valid === 1'b1) nstrobe++;
            if (done === 1'b1) ndone++;
            if (cyc >= 11) begin
                ei = (cyc / 11 - 1 > 8) ? 8 : cyc / 11 - 1;
                checks += 2;
                if (pix_out !== 8'(refp[ei])) begin
                    errors++;
                    $display("FAIL %s pix_out cyc %0d: got %0d want %0d", nm, cyc, pix_out, refp[ei]);
                end
                if (pix_idx !== 5'(ei)) begin
                    errors++;
                    $display("FAIL %s pix_idx cyc %0d: got %0d want %0d", nm, cyc, pix_idx, ei);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks += 2;
        if (nstrobe != 9) begin
            errors++;
            $display("FAIL %s strobe count: got %0d want 9", nm, nstrobe);
        end
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done count: got %0d want 1", nm, ndone);
        end
    endtask

    task automatic check_zero_outputs(input string nm);
        checks++;
        if (mem_addr !== 5'd0 || busy !== 1'b0 || pix_valid !== 1'b0 ||
            pix_out !== 8'd0 || pix_idx !== 5'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: got addr=%0d busy=%b v=%b out=%0d idx=%0d done=%b want all 0",
                     nm, mem_addr, busy, pix_valid, pix_out, pix_idx, done);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_hold");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("idle_no_start");
    endtask

    task automatic test_flat();
        fill_const(32'd100);
        do_run("flat", 0);
        checks++;
        if (refp[4] != 100) begin
            errors++;
            $display("FAIL flat_ref: got %0d want 100", refp[4]);
        end
    endtask

    task automatic test_impulse();
        fill_const(32'd0);
        img[12] = 32'd160;
        do_run("impulse", 0);
    endtask

    task automatic test_upper_bits();
        fill_const(32'hFFFF_FFFF);
        do_run("all_ones", 0);
        fill_const(32'hABCD_EF05);
        do_run("upper_bits", 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 3; n++) begin
            fill_rand();
            do_run("random", 0);
        end
    endtask

    task automatic test_ignored_start();
        fill_rand();
        do_run("ignored_start", 1);
    endtask

    task automatic test_reset_midrun();
        fill_rand();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1 check_zero_outputs("midrun_reset");
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            checks++;
            if (pix_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrun_quiet %0d: got v=%b done=%b busy=%b want 0", i, pix_valid, done, busy);
            end
        end
        do_run("after_reset", 0);
    endtask

    task automatic test_start_held();
        fill_rand();
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 103; cyc++) begin
            if (cyc == 101) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL held_idle busy: got %b want 0", busy);
                end
            end
            if (cyc == 102) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL held_restart busy: got %b want 1", busy);
                end
            end
            if (cyc == 103) begin
                checks++;
                if (mem_addr !== 5'd1) begin
                    errors++;
                    $display("FAIL held_restart addr: got %0d want 1", mem_addr);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        fill_const(32'd0);
        test_reset();
        test_flat();
        test_impulse();
        test_upper_bits();
        test_random();
        test_ignored_start();
        test_reset_midrun();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
